pile_arbitre: RTL and testbench

PILE_ARBITRE -- requirements
Module: pile_arbitre

---
 rtl/pile_arbitre.sv | 122 ++++++++++++
 tb/tb_pile_arbitre.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pile_arbitre.sv
// pile_arbitre: round-robin arbiter granting players A and B plus/moins commands on a shared brick stack.
// Define PILE_ARBITRE_CHECK_EN to add the sticky height-consistency checker and its err output.
module pile_arbitre #(
   parameter int unsigned HAUTEUR_MAX = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       op_a,
   input  logic       op_b,
   input  logic [2:0] Hauteur,
   output logic       plus,
   output logic       moins,
   output logic       ack_a,
   output logic       ack_b,
   output logic       nack_a,
   output logic       nack_b,
   output logic       busy
`ifdef PILE_ARBITRE_CHECK_EN
   ,
   output logic       err
`endif
);

   localparam logic [2:0] HMAX = 3'(HAUTEUR_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DONE} etat_t;

   etat_t etat, etat_suiv;
   logic  pointeur, pointeur_suiv;
   logic  gagnant, gagnant_suiv;
   logic  sel_b, op_sel, refus;
   logic  plus_suiv, moins_suiv, busy_suiv;
   logic  ack_a_suiv, ack_b_suiv, nack_a_suiv, nack_b_suiv;

   always_comb begin
      etat_suiv     = etat;
      pointeur_suiv = pointeur;
      gagnant_suiv  = gagnant;
      plus_suiv     = 1'b0;
      moins_suiv    = 1'b0;
      ack_a_suiv    = 1'b0;
      ack_b_suiv    = 1'b0;
      nack_a_suiv   = 1'b0;
      nack_b_suiv   = 1'b0;
      // B wins when it requests alone or when both request and the pointer favours B
      sel_b  = req_b & (~req_a | pointeur);
      op_sel = sel_b ? op_b : op_a;
      refus  = op_sel ? (Hauteur >= HMAX) : (Hauteur == 3'd0);
      case (etat)
         IDLE: begin
            if (req_a | req_b) begin
               gagnant_suiv  = sel_b;
               pointeur_suiv = ~sel_b;
               if (refus) begin
                  etat_suiv   = DONE;
                  nack_a_suiv = ~sel_b;
                  nack_b_suiv = sel_b;
               end else begin
                  etat_suiv  = ISSUE;
                  plus_suiv  = op_sel;
                  moins_suiv = ~op_sel;
               end
            end
         end
         ISSUE:  etat_suiv = SETTLE;
         SETTLE: begin
            etat_suiv  = DONE;
            ack_a_suiv = ~gagnant;
            ack_b_suiv = gagnant;
         end
         DONE:    etat_suiv = IDLE;
         default: etat_suiv = IDLE;
      endcase
      busy_suiv = (etat_suiv != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         etat     <= IDLE;
         pointeur <= 1'b0;
         gagnant  <= 1'b0;
         plus     <= 1'b0;
         moins    <= 1'b0;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         nack_a   <= 1'b0;
         nack_b   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         etat     <= etat_suiv;
         pointeur <= pointeur_suiv;
         gagnant  <= gagnant_suiv;
         plus     <= plus_suiv;
         moins    <= moins_suiv;
         ack_a    <= ack_a_suiv;
         ack_b    <= ack_b_suiv;
         nack_a   <= nack_a_suiv;
         nack_b   <= nack_b_suiv;
         busy     <= busy_suiv;
      end
   end

`ifdef PILE_ARBITRE_CHECK_EN
   logic [2:0] attendu;

   // plus is high exactly during ISSUE of an add, so it selects the expected direction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         attendu <= '0;
         err     <= 1'b0;
      end else begin
         if (etat == ISSUE)
            attendu <= plus ? (Hauteur + 3'd1) : (Hauteur - 3'd1);
         if ((etat == SETTLE) && (Hauteur != attendu))
            err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pile_arbitre.sv
// Scoreboard bench for pile_arbitre: two instances (default HAUTEUR_MAX and HAUTEUR_MAX=3) with stack-counter models.
module tb_pile_arbitre;

   typedef struct packed { int unsigned cyc; logic [6:0] vec; } ev_t;
   typedef struct packed { int unsigned cyc; logic [1:0] kind; logic [6:0] val; } pr_t;

   // {busy, plus, moins, ack_a, ack_b, nack_a, nack_b}
   localparam logic [6:0] V_PLUS  = 7'b1100000;
   localparam logic [6:0] V_MOINS = 7'b1010000;
   localparam logic [6:0] V_BUSY  = 7'b1000000;
   localparam logic [6:0] V_ACKA  = 7'b1001000;
   localparam logic [6:0] V_ACKB  = 7'b1000100;
   localparam logic [6:0] V_NACKA = 7'b1000010;
   localparam logic [6:0] V_NACKB = 7'b1000001;
   localparam logic [1:0] K_HAUT = 2'd0, K_SORT = 2'd1, K_ERR = 2'd2;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req_a, req_b, op_a, op_b;
   logic [1:0] plus, moins, ack_a, ack_b, nack_a, nack_b, busy, err_obs;
   logic [1:0] charge, gele;
   logic [2:0] haut [2];
   logic [2:0] val_ch [2];
   logic [6:0] obs [2];
   int unsigned cyc = 0;
   int nb_cmp = 0;
   int nb_err = 0;
   ev_t sb [2][$];
   pr_t pr [2][$];
   ev_t e;
   pr_t p;
   logic [6:0] act;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pile_arbitre dut7 (
      .clk(clk), .reset(reset), .req_a(req_a[0]), .req_b(req_b[0]), .op_a(op_a[0]), .op_b(op_b[0]),
      .Hauteur(haut[0]), .plus(plus[0]), .moins(moins[0]), .ack_a(ack_a[0]), .ack_b(ack_b[0]),
      .nack_a(nack_a[0]), .nack_b(nack_b[0]), .busy(busy[0])
`ifdef PILE_ARBITRE_CHECK_EN
      , .err(err_obs[0])
`endif
   );

   pile_arbitre #(.HAUTEUR_MAX(3)) dut3 (
      .clk(clk), .reset(reset), .req_a(req_a[1]), .req_b(req_b[1]), .op_a(op_a[1]), .op_b(op_b[1]),
      .Hauteur(haut[1]), .plus(plus[1]), .moins(moins[1]), .ack_a(ack_a[1]), .ack_b(ack_b[1]),
      .nack_a(nack_a[1]), .nack_b(nack_b[1]), .busy(busy[1])
`ifdef PILE_ARBITRE_CHECK_EN
      , .err(err_obs[1])
`endif
   );

`ifndef PILE_ARBITRE_CHECK_EN
   assign err_obs = '0;
`endif

   assign obs[0] = {busy[0], plus[0], moins[0], ack_a[0], ack_b[0], nack_a[0], nack_b[0]};
   assign obs[1] = {busy[1], plus[1], moins[1], ack_a[1], ack_b[1], nack_a[1], nack_b[1]};

   // stack counter models; gele freezes the add path to emulate a faulty counter
   always @(posedge clk)
      for (int d = 0; d < 2; d++)
         if (charge[d]) haut[d] <= val_ch[d];
         else if (plus[d] && !gele[d]) haut[d] <= haut[d] + 3'd1;
         else if (moins[d]) haut[d] <= haut[d] - 3'd1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         while (sb[d].size() != 0 && sb[d][0].cyc < cyc) begin
            e = sb[d].pop_front();
            nb_cmp++; nb_err++;
            $display("FAIL missing_event dut%0d cyc=%0d actual=none required=%b@%0d", d, cyc, e.vec, e.cyc);
         end
         if (obs[d] != 7'b0) begin
            nb_cmp++;
            if (sb[d].size() == 0 || sb[d][0].cyc != cyc) begin
               nb_err++;
               $display("FAIL unexpected_event dut%0d cyc=%0d actual=%b required=nothing", d, cyc, obs[d]);
            end else begin
               e = sb[d].pop_front();
               if (e.vec != obs[d]) begin
                  nb_err++;
                  $display("FAIL event dut%0d cyc=%0d actual=%b required=%b", d, cyc, obs[d], e.vec);
               end
            end
         end
         while (pr[d].size() != 0 && pr[d][0].cyc <= cyc) begin
            p = pr[d].pop_front();
            case (p.kind)
               K_HAUT:  act = {4'b0, haut[d]};
               K_SORT:  act = obs[d];
               default: act = {6'b0, err_obs[d]};
            endcase
            nb_cmp++;
            if (p.cyc != cyc || act != p.val) begin
               nb_err++;
               $display("FAIL probe%0d dut%0d cyc=%0d actual=%b required=%b@%0d", p.kind, d, cyc, act, p.val, p.cyc);
            end
         end
      end
   end

   task automatic sonde(input int d, input int unsigned c, input logic [1:0] k, input logic [6:0] v);
      pr[d].push_back(pr_t'{cyc: c, kind: k, val: v});
   endtask

   task automatic pousse(input int d, input int unsigned c, input logic [6:0] v);
      sb[d].push_back(ev_t'{cyc: c, vec: v});
   endtask

   task automatic charger(input int d, input logic [2:0] v);
      charge[d] = 1'b1; val_ch[d] = v;
      @(negedge clk);
      charge[d] = 1'b0;
   endtask

   task automatic impulsion_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // single requester b (0=A, 1=B); accepte and h are the hand-derived outcome and final height
   task automatic operation(input int d, input logic b, input logic op, input logic accepte, input logic [2:0] h);
      int unsigned c = cyc;
      if (b) begin req_b[d] = 1'b1; op_b[d] = op; end
      else   begin req_a[d] = 1'b1; op_a[d] = op; end
      if (accepte) begin
         pousse(d, c + 1, op ? V_PLUS : V_MOINS);
         pousse(d, c + 2, V_BUSY);
         pousse(d, c + 3, b ? V_ACKB : V_ACKA);
         repeat (3) @(negedge clk);
      end else begin
         pousse(d, c + 1, b ? V_NACKB : V_NACKA);
         @(negedge clk);
      end
      if (b) req_b[d] = 1'b0; else req_a[d] = 1'b0;
      sonde(d, cyc + 1, K_HAUT, {4'b0, h});
      @(negedge clk);
   endtask

   // both players add simultaneously, winners re-request so grants alternate starting with A
   task automatic alterne(input int d, input int n);
      int unsigned c = cyc;
      req_a[d] = 1'b1; req_b[d] = 1'b1; op_a[d] = 1'b1; op_b[d] = 1'b1;
      for (int k = 0; k < n; k++) begin
         pousse(d, c + 4 * k + 1, V_PLUS);
         pousse(d, c + 4 * k + 2, V_BUSY);
         pousse(d, c + 4 * k + 3, (k % 2 == 1) ? V_ACKB : V_ACKA);
      end
      for (int k = 0; k < n; k++) begin
         repeat (3) @(negedge clk);
         if (k % 2 == 1) req_b[d] = 1'b0; else req_a[d] = 1'b0;
         @(negedge clk);
         if (k < n - 2) begin
            if (k % 2 == 1) req_b[d] = 1'b1; else req_a[d] = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned c;
      reset = 1'b1;
      req_a = '0; req_b = '0; op_a = '0; op_b = '0;
      gele = '0; charge = '1; val_ch[0] = 3'd0; val_ch[1] = 3'd0;
      @(negedge clk);
      charge = '0;
      for (int d = 0; d < 2; d++) begin
         sonde(d, cyc + 1, K_SORT, 7'b0);
         sonde(d, cyc + 1, K_HAUT, 7'b0);
      end
      @(negedge clk);
      reset = 1'b0;
      operation(0, 1'b0, 1'b1, 1'b1, 3'd1);
      charger(0, 3'd0);
      operation(0, 1'b1, 1'b0, 1'b0, 3'd0);
      charger(0, 3'd6);
      operation(0, 1'b0, 1'b1, 1'b1, 3'd7);
      operation(0, 1'b0, 1'b1, 1'b0, 3'd7);
      operation(0, 1'b1, 1'b0, 1'b1, 3'd6);
      charger(0, 3'd0);
      operation(0, 1'b0, 1'b0, 1'b0, 3'd0);
      charger(1, 3'd3);
      operation(1, 1'b0, 1'b1, 1'b0, 3'd3);
      operation(1, 1'b0, 1'b0, 1'b1, 3'd2);
      operation(1, 1'b1, 1'b1, 1'b1, 3'd3);
      operation(1, 1'b1, 1'b1, 1'b0, 3'd3);

      impulsion_reset();
      alterne(0, 4);
      sonde(0, cyc + 1, K_HAUT, 7'd4);
      @(negedge clk);

      // reset pulse inside ISSUE, entirely between two rising edges
      c = cyc;
      req_a[0] = 1'b1; op_a[0] = 1'b1;
      pousse(0, c + 1, V_PLUS);
      @(negedge clk);
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      req_a[0] = 1'b0;
      sonde(0, cyc + 1, K_SORT, 7'b0);
      sonde(0, cyc + 2, K_HAUT, 7'd4);
      @(negedge clk);
      alterne(0, 2);
      sonde(0, cyc + 1, K_HAUT, 7'd6);
      @(negedge clk);

`ifdef PILE_ARBITRE_CHECK_EN
      impulsion_reset();
      sonde(0, cyc + 1, K_ERR, 7'd0);
      charger(0, 3'd2);
      gele[0] = 1'b1;
      operation(0, 1'b0, 1'b1, 1'b1, 3'd2);
      sonde(0, cyc + 1, K_ERR, 7'd1);
      operation(0, 1'b1, 1'b0, 1'b1, 3'd1);
      sonde(0, cyc + 1, K_ERR, 7'd1);
      gele[0] = 1'b0;
      @(negedge clk);
      impulsion_reset();
      sonde(0, cyc + 1, K_ERR, 7'd0);
`endif

      repeat (4) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nb_cmp, nb_err);
      $finish;
   end

endmodule
